// File: rtl/scanline_audio_synth_if.sv
// Bundles the scanline synth timing ticks, note-table write port and audio outputs.
// Latency: none, wires only.
// Backpressure: none; ticks and cfg writes are single-clk strobes, always accepted.
interface scanline_audio_synth_if #(
  parameter int NUM_VOICES = 3,
  parameter int DIV_W      = 9,
  parameter int ENV_W      = 5,
  parameter int STEPS      = 8
);
  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int LW = ENV_W + $clog2(NUM_VOICES + 2);

  logic          line_tick;
  logic          frame_tick;
  logic          cfg_we;
  logic [VW-1:0] cfg_voice;
  logic [SW-1:0] cfg_step;
  logic [DIV_W-1:0] cfg_div;
  logic [SW-1:0] step;
  logic [LW-1:0] level;
  logic          audio;

  modport master (
    output line_tick, frame_tick, cfg_we, cfg_voice, cfg_step, cfg_div,
    input  step, level, audio
  );

  modport slave (
    input  line_tick, frame_tick, cfg_we, cfg_voice, cfg_step, cfg_div,
    output step, level, audio
  );
endinterface

// File: rtl/scanline_audio_synth.sv
// Multi-voice square-wave synth + step sequencer, mixed level emitted as per-line PWM on audio.
// Latency: level lags one line_tick; audio follows pwm_cnt by 1 clk (pulse starts 1 clk after line_tick).
// Backpressure: none; optional noise voice enabled by defining SCANLINE_SYNTH_NOISE_EN.
module scanline_audio_synth #(
  parameter int NUM_VOICES      = 3,
  parameter int DIV_W           = 9,
  parameter int ENV_W           = 5,
  parameter int STEPS           = 8,
  parameter int FRAMES_PER_STEP = 32,
  parameter int LFSR_W          = 16
) (
  input logic clk,
  input logic rst_n,
  scanline_audio_synth_if.slave bus
);
  localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int LW = ENV_W + $clog2(NUM_VOICES + 2);
  localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [ENV_W-1:0] ENV_MAX = '1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_STEP - 1);

  // The step counter wraps by natural overflow, and the LFSR taps need a few bits.
  if (LFSR_W < 6 || (STEPS & (STEPS - 1)) != 0) begin : g_bad_cfg
    $error("scanline_audio_synth: STEPS must be a power of 2 and LFSR_W >= 6");
  end

  logic [DIV_W-1:0] note_tab [NUM_VOICES][STEPS];
  logic [FW-1:0]    frame_cnt;
  logic [SW-1:0]    cur_step;
  logic [DIV_W-1:0] cnt      [NUM_VOICES];
  logic             phase    [NUM_VOICES];
  logic [ENV_W-1:0] env      [NUM_VOICES];
  logic [DIV_W-1:0] div_cur  [NUM_VOICES];
  logic [LW-1:0]    mix;
  logic [LW-1:0]    mix_level;
  logic [LW-1:0]    pwm_cnt;
  logic             audio_bit;
  logic             trig;

`ifdef SCANLINE_SYNTH_NOISE_EN
  logic [LFSR_W-1:0] lfsr;
  logic [ENV_W-1:0]  noise_env;
  // x^16+x^14+x^13+x^11 is maximal-length for the default 16-bit width.
  wire               lfsr_fb = lfsr[LFSR_W-1] ^ lfsr[LFSR_W-3] ^ lfsr[LFSR_W-4] ^ lfsr[LFSR_W-6];
`endif

  assign bus.step  = cur_step;
  assign bus.level = mix_level;
  assign bus.audio = audio_bit;

  // Trigger strobe, current-step note lookup and mix of pre-update voice state.
  always_comb begin
    trig    = bus.frame_tick && (frame_cnt == '0);
    mix     = '0;
    div_cur = '{default: '0};
    for (int v = 0; v < NUM_VOICES; v++) begin
      div_cur[v] = note_tab[v][cur_step];
      if (phase[v]) mix = mix + LW'(env[v]);
    end
`ifdef SCANLINE_SYNTH_NOISE_EN
    if (lfsr[0]) mix = mix + LW'(noise_env);
`endif
  end

  // Note table: one write per clk; out-of-range voices are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VOICES; v++)
        for (int s = 0; s < STEPS; s++)
          note_tab[v][s] <= '0;
    end else if (bus.cfg_we && (int'(bus.cfg_voice) < NUM_VOICES)) begin
      note_tab[bus.cfg_voice][bus.cfg_step] <= bus.cfg_div;
    end
  end

  // Sequencer: frames per step, step advances on the frame counter wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      cur_step  <= '0;
    end else if (bus.frame_tick) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt <= '0;
        cur_step  <= cur_step + SW'(1);
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

  // Per-voice oscillator and envelope; trigger assignments come last so they win.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        cnt[v]   <= '0;
        phase[v] <= 1'b0;
        env[v]   <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (bus.line_tick) begin
          if (div_cur[v] == '0) begin
            cnt[v]   <= '0;
            phase[v] <= 1'b0;
          end else if (cnt[v] >= div_cur[v]) begin
            cnt[v]   <= '0;
            phase[v] <= ~phase[v];
          end else begin
            cnt[v] <= cnt[v] + DIV_W'(1);
          end
        end
        if (bus.frame_tick) begin
          if (trig && (div_cur[v] != '0)) begin
            env[v]   <= ENV_MAX;
            cnt[v]   <= '0;
            phase[v] <= 1'b0;
          end else if (trig) begin
            env[v] <= '0;
          end else if (env[v] != '0) begin
            env[v] <= env[v] - ENV_W'(1);
          end
        end
      end
    end
  end

`ifdef SCANLINE_SYNTH_NOISE_EN
  // Noise voice: LFSR steps per line, retriggers on odd steps, decays by 2 per frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr      <= LFSR_W'(1);
      noise_env <= '0;
    end else begin
      if (bus.line_tick) lfsr <= {lfsr[LFSR_W-2:0], lfsr_fb};
      if (bus.frame_tick) begin
        if (trig && cur_step[0])           noise_env <= ENV_MAX;
        else if (noise_env > ENV_W'(1))    noise_env <= noise_env - ENV_W'(2);
        else                               noise_env <= '0;
      end
    end
  end
`endif

  // Level latch and PWM: counter restarts each line and saturates, audio high while below level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mix_level <= '0;
      pwm_cnt   <= '0;
      audio_bit <= 1'b0;
    end else begin
      if (bus.line_tick) begin
        mix_level <= mix;
        pwm_cnt   <= '0;
      end else if (pwm_cnt != '1) begin
        pwm_cnt <= pwm_cnt + LW'(1);
      end
      audio_bit <= (pwm_cnt < mix_level);
    end
  end
endmodule
